// File: rtl/axi_rd_slave.sv
// AXI4 read-only slave backed by an internal word memory with a side write port.
// Optional macro AXI_RD_SLAVE_RANGE_CHK_EN returns DECERR for beats beyond the memory size.
`timescale 1ns/1ps

module axi_rd_slave #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_DEPTH  = 256,
  parameter int RD_LAT     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ID_WIDTH-1:0]          ARID,
  input  logic [ADDR_WIDTH-1:0]        ARADDR,
  input  logic [7:0]                   ARLEN,
  input  logic [2:0]                   ARSIZE,
  input  logic [1:0]                   ARBURST,
  input  logic [3:0]                   ARREGION,
  input  logic                         ARVALID,
  output logic                         ARREADY,
  output logic [ID_WIDTH-1:0]          RID,
  output logic [DATA_WIDTH-1:0]        RDATA,
  output logic [1:0]                   RRESP,
  output logic                         RLAST,
  output logic                         RVALID,
  input  logic                         RREADY,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0]        mem_wdata,
  output logic                         busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [3:0] LAT_LAST = (RD_LAT > 0) ? 4'(RD_LAT - 1) : 4'd0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_beat;
  logic [2:0]            r_size;
  logic                  r_fixed;
  logic                  r_slverr;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_ram_q;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_adv;
  logic                  w_done;
  logic                  w_start;
  logic                  w_launch;
  logic                  w_ar_slverr;
  logic [ADDR_WIDTH-1:0] w_step;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [ADDR_WIDTH-1:0] w_ld_addr;
  logic                  w_ld_slverr;
  logic                  w_ld_last;
  logic                  w_ld_oor;
  logic [1:0]            w_ld_resp;
  logic [IDX_W-1:0]      w_ld_idx;
  logic                  w_unused;

  assign w_unused    = ^ARREGION;
  assign w_ar_hs     = ARVALID && (r_state == S_IDLE);
  assign w_r_hs      = r_rvalid && RREADY;
  assign w_adv       = w_r_hs && !r_rlast;
  assign w_done      = w_r_hs && r_rlast;
  assign w_ar_slverr = ARBURST[1] || (ARSIZE > 3'(LSB));
  assign w_start     = (w_ar_hs && (RD_LAT == 0)) ||
                       ((r_state == S_WAIT) && (r_cnt == LAT_LAST));
  assign w_launch    = w_start || w_adv;
  assign w_step      = r_fixed ? '0 : (ADDR_WIDTH'(1) << r_size);
  assign w_next_addr = r_addr + w_step;

  // Selects the address/attributes of the beat being loaded into the output registers.
  always_comb begin
    w_ld_addr   = w_next_addr;
    w_ld_slverr = r_slverr;
    w_ld_last   = ((r_beat + 8'd1) == r_len);
    if (r_state == S_IDLE) begin
      w_ld_addr   = ARADDR;
      w_ld_slverr = w_ar_slverr;
      w_ld_last   = (ARLEN == 8'd0);
    end else if (r_state == S_WAIT) begin
      w_ld_addr   = r_addr;
      w_ld_last   = (r_len == 8'd0);
    end
  end

`ifdef AXI_RD_SLAVE_RANGE_CHK_EN
  assign w_ld_oor = (w_ld_addr >= ADDR_WIDTH'(MEM_DEPTH * BYTES));
`else
  assign w_ld_oor = 1'b0;
`endif

  assign w_ld_resp = w_ld_slverr ? RESP_SLVERR : (w_ld_oor ? RESP_DECERR : RESP_OKAY);
  assign w_ld_idx  = w_ld_addr[LSB +: IDX_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_id     <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_beat   <= '0;
      r_size   <= '0;
      r_fixed  <= 1'b0;
      r_slverr <= 1'b0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_rresp  <= RESP_OKAY;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ar_hs) begin
            r_id     <= ARID;
            r_addr   <= ARADDR;
            r_len    <= ARLEN;
            r_size   <= ARSIZE;
            r_fixed  <= (ARBURST == 2'b00);
            r_slverr <= w_ar_slverr;
            r_cnt    <= '0;
            r_state  <= (RD_LAT == 0) ? S_BURST : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == LAT_LAST) begin
            r_state <= S_BURST;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_BURST: begin
          if (w_done) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A new beat is loaded either on burst start or when the current beat is taken.
      if (w_launch) begin
        r_rvalid <= 1'b1;
        r_rlast  <= w_ld_last;
        r_rresp  <= w_ld_resp;
        r_addr   <= w_ld_addr;
        r_beat   <= w_start ? 8'd0 : (r_beat + 8'd1);
      end else if (w_done) begin
        r_rvalid <= 1'b0;
        r_rlast  <= 1'b0;
        r_rresp  <= RESP_OKAY;
      end
    end
  end

  // Memory is deliberately not reset; read is registered and sees pre-write data.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      r_mem[mem_waddr] <= mem_wdata;
    end
    if (w_launch) begin
      r_ram_q <= r_mem[w_ld_idx];
    end
  end

  assign ARREADY = (r_state == S_IDLE);
  assign busy    = (r_state != S_IDLE);
  assign RVALID  = r_rvalid;
  assign RLAST   = r_rlast;
  assign RRESP   = r_rresp;
  assign RID     = r_id;
  assign RDATA   = (r_rvalid && (r_rresp == RESP_OKAY)) ? r_ram_q : '0;

endmodule

// File: tb/tb_axi_rd_slave.sv
// Scoreboard bench for axi_rd_slave: a reference model queues expected beats at AR issue,
// a negedge monitor pops and compares them; honours AXI_RD_SLAVE_RANGE_CHK_EN.
`timescale 1ns/1ps

module tb_axi_rd_slave;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ARID = '0;
  logic [31:0] ARADDR = '0;
  logic [7:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = '0;
  logic [1:0]  ARBURST = '0;
  logic [3:0]  ARREGION = 4'hF;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b1;
  logic        mem_we = 1'b0;
  logic [7:0]  mem_waddr = '0;
  logic [63:0] mem_wdata = '0;
  logic        busy;

  always #5 clk = ~clk;

  axi_rd_slave #(
    .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(64), .MEM_DEPTH(256), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .busy(busy)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       sb[$];
  logic [63:0] mem_m [256];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          hs_cyc = 0;
  bit          wait_first = 1'b0;
  int          nbeats = 0;
  int          rr_mode = 0;
  bit          stalled = 1'b0;
  logic [71:0] held = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RREADY pattern generator: always-ready, 1-0-0 toggle, or random.
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      k++;
      case (rr_mode)
        1:       RREADY = (k % 3 == 0);
        2:       RREADY = 1'($urandom_range(0, 1));
        default: RREADY = 1'b1;
      endcase
    end
  end

  // Monitor: latency, stall stability, AR blocking while busy, beat scoreboard.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled    = 1'b0;
        wait_first = 1'b0;
      end else begin
        if (ARVALID && ARREADY) begin
          hs_cyc     = cyc;
          wait_first = 1'b1;
        end
        if (ARVALID && busy) chk("arready_busy", ARREADY, 0);
        if (stalled) chk("stall_hold", {RVALID, RLAST, RRESP, RID, RDATA}, held);
        if (RVALID && wait_first) begin
          chk("first_lat", cyc - hs_cyc, 1 + RD_LAT);
          wait_first = 1'b0;
        end
        if (RVALID && RREADY) begin
          chk("sb_nonempty", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rid", RID, e.id);
            chk("rdata", RDATA, e.data);
            chk("rresp", RRESP, e.resp);
            chk("rlast", RLAST, e.last);
            $display("beat id=%0h data=%016h resp=%0d last=%0d", RID, RDATA, RRESP, RLAST);
          end
          nbeats++;
        end
        stalled = RVALID && !RREADY;
        held    = {RVALID, RLAST, RRESP, RID, RDATA};
      end
    end
  end

  task automatic mem_write(input logic [7:0] idx, input logic [63:0] data);
    @(posedge clk);
    #1;
    mem_we    = 1'b1;
    mem_waddr = idx;
    mem_wdata = data;
    mem_m[idx] = data;
    @(posedge clk);
    #1;
    mem_we = 1'b0;
  endtask

  task automatic push_exp(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    beat_t e;
    a = addr;
    for (int b = 0; b <= int'(len); b++) begin
      e.id   = id;
      e.last = (b == int'(len));
      if (burst[1] || size > 3'd3) begin
        e.resp = 2'b10;
        e.data = '0;
      end
`ifdef AXI_RD_SLAVE_RANGE_CHK_EN
      else if (a >= 32'd2048) begin
        e.resp = 2'b11;
        e.data = '0;
      end
`endif
      else begin
        e.resp = 2'b00;
        e.data = mem_m[a[10:3]];
      end
      sb.push_back(e);
      if (burst == 2'b01) a = a + (32'd1 << size);
    end
  endtask

  task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    bit hs;
    hs = 1'b0;
    push_exp(id, addr, len, size, burst);
    $display("ar id=%0h addr=%08h len=%0d size=%0d burst=%0d", id, addr, len, size, burst);
    @(posedge clk);
    #1;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
    ARVALID = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      hs = ARREADY;
      @(posedge clk);
      #1;
      if (hs) break;
    end
    ARVALID = 1'b0;
    chk("ar_accept", hs, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain", sb.size(), 0);
    chk("post_rvalid", RVALID, 0);
    chk("post_arready", ARREADY, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    repeat (2) @(negedge clk);
    chk("rst_arready", ARREADY, 1);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_outs", {RLAST, RRESP, RID, RDATA, busy}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    mem_write(8'd0, 64'h11);
    mem_write(8'd1, 64'h22);
    mem_write(8'd2, 64'h33);
    mem_write(8'd3, 64'h44);
    for (int w = 4; w < 16; w++) mem_write(8'(w), {$urandom, $urandom});
    mem_write(8'd255, 64'hFF00_FF00_1234_5678);

    rr_mode = 0;
    issue_ar(4'd5, 32'h0, 8'd3, 3'd3, 2'b01);
    drain();

    rr_mode = 1;
    issue_ar(4'd5, 32'h0, 8'd3, 3'd3, 2'b01);
    drain();

    rr_mode = 0;
    issue_ar(4'd6, 32'h8, 8'd2, 3'd3, 2'b00);
    drain();

    // WRAP burst with a second request held while it runs; narrow INCR follows.
    issue_ar(4'd3, 32'h40, 8'd1, 3'd3, 2'b10);
    issue_ar(4'd7, 32'h10, 8'd3, 3'd2, 2'b01);
    drain();

    issue_ar(4'd9, 32'h0, 8'd2, 3'd4, 2'b01);
    drain();
    issue_ar(4'hA, 32'h18, 8'd0, 3'd3, 2'b11);
    drain();

    // Reset after beat 2 of an 8-beat burst.
    target = nbeats + 2;
    issue_ar(4'd2, 32'h0, 8'd7, 3'd3, 2'b01);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (nbeats >= target) break;
    end
    chk("rst_wait", nbeats >= target, 1);
    #1;
    rst = 1'b1;
    sb.delete();
    repeat (3) begin
      @(negedge clk);
      chk("midrst_rvalid", RVALID, 0);
      chk("midrst_arready", ARREADY, 1);
      chk("midrst_busy", busy, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue_ar(4'd4, 32'h8, 8'd3, 3'd3, 2'b01);
    drain();

    issue_ar(4'd1, 32'h7F8, 8'd1, 3'd3, 2'b01);
    drain();
    issue_ar(4'd8, 32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01);
    drain();

    rr_mode = 2;
    issue_ar(4'hC, 32'h20, 8'd7, 3'd3, 2'b01);
    drain();
    issue_ar(4'hD, 32'h38, 8'd3, 3'd3, 2'b00);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
